seq_decode_writeback: RTL

- Downstream neighbour of the SEQ fetch stage: takes icode/rA/rB from fetch and holds the Y86-64 program register file (15 × 64-bit, %rax..%r14).
- Decode half is combinational. It derives srcA/srcB/dstE/dstM and reads valA/valB.
- Write-back half is sequential. At each rising edge it commits valE to dstE and valM to dstM.
- Holds a sticky halted flag that freezes architectural state after a halt instruction.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/y86_regfile.sv | 46 ++++
 rtl/seq_decode_writeback.sv | 113 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants: instruction codes, register IDs, data width.
package y86_pkg;

   localparam int WIDTH = 64;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_CMOVXX = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   localparam logic [3:0] REG_RAX  = 4'h0;
   localparam logic [3:0] REG_RCX  = 4'h1;
   localparam logic [3:0] REG_RDX  = 4'h2;
   localparam logic [3:0] REG_RBX  = 4'h3;
   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] REG_RBP  = 4'h5;
   localparam logic [3:0] REG_RSI  = 4'h6;
   localparam logic [3:0] REG_RDI  = 4'h7;
   localparam logic [3:0] REG_R8   = 4'h8;
   localparam logic [3:0] REG_R9   = 4'h9;
   localparam logic [3:0] REG_R10  = 4'hA;
   localparam logic [3:0] REG_R11  = 4'hB;
   localparam logic [3:0] REG_R12  = 4'hC;
   localparam logic [3:0] REG_R13  = 4'hD;
   localparam logic [3:0] REG_R14  = 4'hE;
   localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15-entry Y86-64 register file, two read ports, debug port, E/M write ports.
module y86_regfile
   import y86_pkg::*;
#(
   parameter int               WIDTH      = 64,
   parameter logic [WIDTH-1:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [3:0]       i_src_a,
   input  logic [3:0]       i_src_b,
   input  logic [3:0]       i_dbg_addr,
   output logic [WIDTH-1:0] o_val_a,
   output logic [WIDTH-1:0] o_val_b,
   output logic [WIDTH-1:0] o_dbg_data,
   input  logic             i_we,
   input  logic [3:0]       i_dst_e,
   input  logic [3:0]       i_dst_m,
   input  logic [WIDTH-1:0] i_val_e,
   input  logic [WIDTH-1:0] i_val_m
);

   logic [WIDTH-1:0] r_regs [0:14];

   // M write is issued after E so it wins when both target the same register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 15; i++) begin
            r_regs[i] <= '0;
         end
         r_regs[REG_RSP] <= STACK_INIT;
      end else if (i_we) begin
         if (i_dst_e != REG_NONE) begin
            r_regs[i_dst_e] <= i_val_e;
         end
         if (i_dst_m != REG_NONE) begin
            r_regs[i_dst_m] <= i_val_m;
         end
      end
   end

   assign o_val_a    = (i_src_a    == REG_NONE) ? '0 : r_regs[i_src_a];
   assign o_val_b    = (i_src_b    == REG_NONE) ? '0 : r_regs[i_src_b];
   assign o_dbg_data = (i_dbg_addr == REG_NONE) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/seq_decode_writeback.sv
// rtl/seq_decode_writeback.sv - Y86-64 SEQ decode and write-back with sticky halt.
module seq_decode_writeback
   import y86_pkg::*;
#(
   parameter int               WIDTH      = y86_pkg::WIDTH,
   parameter logic [WIDTH-1:0] STACK_INIT = 64'h0000_0000_0000_0200,
   parameter logic [3:0]       RNONE      = 4'hF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       icode,
   input  logic             cnd,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [WIDTH-1:0] valE,
   input  logic [WIDTH-1:0] valM,
   input  logic             instr_valid,
   input  logic             halt_in,
   output logic [3:0]       srcA,
   output logic [3:0]       srcB,
   output logic [3:0]       dstE,
   output logic [3:0]       dstM,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB,
   output logic             halted,
   input  logic [3:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic r_halted;
   logic w_we;

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         I_CMOVXX: begin
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         I_IRMOVQ: dstE = rB;
         I_RMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         I_MRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         I_OPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         I_CALL: begin
            srcB = REG_RSP;
            dstE = REG_RSP;
         end
         I_RET: begin
            srcA = REG_RSP;
            srcB = REG_RSP;
            dstE = REG_RSP;
         end
         I_PUSHQ: begin
            srcA = rA;
            srcB = REG_RSP;
            dstE = REG_RSP;
         end
         I_POPQ: begin
            srcA = REG_RSP;
            srcB = REG_RSP;
            dstE = REG_RSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   // A halting instruction never commits its own results
   assign w_we = instr_valid && !r_halted && !halt_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if (instr_valid && halt_in) begin
         r_halted <= 1'b1;
      end
   end

   assign halted = r_halted;

   y86_regfile #(
      .WIDTH      (WIDTH),
      .STACK_INIT (STACK_INIT)
   ) u_regfile (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_src_a    (srcA),
      .i_src_b    (srcB),
      .i_dbg_addr (dbg_addr),
      .o_val_a    (valA),
      .o_val_b    (valB),
      .o_dbg_data (dbg_data),
      .i_we       (w_we),
      .i_dst_e    (dstE),
      .i_dst_m    (dstM),
      .i_val_e    (valE),
      .i_val_m    (valM)
   );

endmodule
